// File: rtl/product_accumulator.sv
// product_accumulator: sums N_TERMS consecutive 8-bit products into one saturated ACC_W-bit result
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    product handshake; in_ready is high only while collecting terms
//   prod                 unsigned 8-bit product
//   flush                synchronous discard of partial sum and any held result
//   out_valid/out_ready  result handshake
//   acc_out, ovf         registered result and its saturation flag
module product_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       prod,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf
);
    typedef enum logic {ACCUM, HOLD} state_t;
    state_t           r_state;
    state_t           w_next_state;
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic             r_ovf;
    logic [ACC_W-1:0] r_acc_out;
    logic             r_ovf_out;
    logic             w_accept;
    logic             w_last;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_new_acc;
    logic             w_new_ovf;
    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == HOLD);
    assign acc_out   = r_acc_out;
    assign ovf       = r_ovf_out;
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_last    = (r_cnt == 8'(N_TERMS - 1));
    // one extra bit catches the carry out that signals saturation
    assign w_sum     = {1'b0, r_acc} + {{(ACC_W - 7){1'b0}}, prod};
    assign w_new_acc = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    assign w_new_ovf = r_ovf | w_sum[ACC_W];
    always_comb begin
        w_next_state = r_state;
        if (flush)
            w_next_state = ACCUM;
        else if (w_accept && w_last)
            w_next_state = HOLD;
        else if (r_state == HOLD && out_ready)
            w_next_state = ACCUM;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ACCUM;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_acc_out <= '0;
            r_ovf_out <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (flush) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_acc_out <= w_new_acc;
                    r_ovf_out <= w_new_ovf;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_ovf     <= 1'b0;
                end else begin
                    r_acc <= w_new_acc;
                    r_ovf <= w_new_ovf;
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed checks of product_accumulator at ACC_W=12 and ACC_W=9
module tb_product_accumulator;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  prod;
    logic        flush;
    logic        out_ready;
    logic        in_ready_a, in_ready_b;
    logic        out_valid_a, out_valid_b;
    logic [11:0] acc_out_a;
    logic [8:0]  acc_out_b;
    logic        ovf_a, ovf_b;
    int          checks;
    int          errors;

    product_accumulator #(.N_TERMS(4), .ACC_W(12)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .prod(prod),
        .flush(flush), .out_valid(out_valid_a), .out_ready(out_ready), .acc_out(acc_out_a), .ovf(ovf_a)
    );
    product_accumulator #(.N_TERMS(4), .ACC_W(9)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .prod(prod),
        .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready), .acc_out(acc_out_b), .ovf(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task test_reset;
        rst = 1'b1; in_valid = 1'b0; prod = '0; flush = 1'b0; out_ready = 1'b1;
        #12;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid_a); end
        checks++; if (acc_out_a !== 12'd0) begin errors++; $display("FAIL reset_acc_out got %0d want 0", acc_out_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf_a); end
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready_a); end
        rst = 1'b0;
        tick;
        checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin errors++; $display("FAIL post_reset ov=%b ir=%b want 0 1", out_valid_a, in_ready_a); end
    endtask

    task test_basic_and_saturation;
        out_ready = 1'b1; in_valid = 1'b1; prod = 8'd225;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL basic_early_valid term %0d got %b want 0", i, out_valid_a); end
        end
        tick;
        in_valid = 1'b0;
        checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid_a); end
        checks++; if (acc_out_a !== 12'd900 || ovf_a !== 1'b0) begin errors++; $display("FAIL basic_sum got %0d/%b want 900/0", acc_out_a, ovf_a); end
        checks++; if (acc_out_b !== 9'd511 || ovf_b !== 1'b1) begin errors++; $display("FAIL sat_sum got %0d/%b want 511/1", acc_out_b, ovf_b); end
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL hold_in_ready got %b want 0", in_ready_a); end
        tick;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got %b want 0", out_valid_a); end
        in_valid = 1'b1; prod = 8'd1;
        repeat (4) tick;
        in_valid = 1'b0;
        checks++; if (acc_out_b !== 9'd4 || ovf_b !== 1'b0 || out_valid_b !== 1'b1) begin errors++; $display("FAIL sat_clear got %0d/%b/%b want 4/0/1", acc_out_b, ovf_b, out_valid_b); end
        checks++; if (acc_out_a !== 12'd4) begin errors++; $display("FAIL small_sum got %0d want 4", acc_out_a); end
        tick;
    endtask

    task test_back_pressure;
        out_ready = 1'b0; in_valid = 1'b1; prod = 8'd25;
        repeat (4) tick;
        prod = 8'd7;
        for (int i = 0; i < 5; i++) begin
            checks++; if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1 || acc_out_a !== 12'd100) begin errors++; $display("FAIL bp_hold cycle %0d ir=%b ov=%b acc=%0d want 0 1 100", i, in_ready_a, out_valid_a, acc_out_a); end
            tick;
        end
        out_ready = 1'b1;
        tick;
        checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin errors++; $display("FAIL bp_release ir=%b ov=%b want 1 0", in_ready_a, out_valid_a); end
        repeat (3) tick;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL bp_early got %b want 0", out_valid_a); end
        tick;
        in_valid = 1'b0;
        checks++; if (out_valid_a !== 1'b1 || acc_out_a !== 12'd28) begin errors++; $display("FAIL bp_next_group ov=%b acc=%0d want 1 28", out_valid_a, acc_out_a); end
        tick;
    endtask

    task test_bubbles;
        logic [7:0] vals [4];
        vals = '{8'd10, 8'd20, 8'd30, 8'd40};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; prod = vals[i];
            tick;
            in_valid = 1'b0; prod = 8'd200;
            if (i < 3) begin
                tick; tick;
                checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL bubble_early term %0d got %b want 0", i, out_valid_a); end
            end
        end
        checks++; if (out_valid_a !== 1'b1 || acc_out_a !== 12'd100) begin errors++; $display("FAIL bubble_sum ov=%b acc=%0d want 1 100", out_valid_a, acc_out_a); end
        tick;
    endtask

    task test_flush;
        out_ready = 1'b1; in_valid = 1'b1;
        prod = 8'd50; tick;
        prod = 8'd60; tick;
        flush = 1'b1; prod = 8'd99; tick;
        flush = 1'b0; prod = 8'd1;
        checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin errors++; $display("FAIL flush_accum ov=%b ir=%b want 0 1", out_valid_a, in_ready_a); end
        repeat (3) tick;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL flush_cnt got %b want 0", out_valid_a); end
        out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        checks++; if (out_valid_a !== 1'b1 || acc_out_a !== 12'd4) begin errors++; $display("FAIL flush_sum ov=%b acc=%0d want 1 4", out_valid_a, acc_out_a); end
        flush = 1'b1; tick; flush = 1'b0;
        checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin errors++; $display("FAIL flush_hold ov=%b ir=%b want 0 1", out_valid_a, in_ready_a); end
        out_ready = 1'b1;
    endtask

    task test_reset_mid;
        in_valid = 1'b1; prod = 8'd9;
        tick; tick;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid_a !== 1'b0 || acc_out_a !== 12'd0 || ovf_a !== 1'b0 || in_ready_a !== 1'b1) begin errors++; $display("FAIL async_reset ov=%b acc=%0d ovf=%b ir=%b want 0 0 0 1", out_valid_a, acc_out_a, ovf_a, in_ready_a); end
        #2 rst = 1'b0;
        in_valid = 1'b1; prod = 8'd5;
        repeat (3) tick;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_partial_lost got %b want 0", out_valid_a); end
        tick;
        in_valid = 1'b0;
        checks++; if (out_valid_a !== 1'b1 || acc_out_a !== 12'd20 || ovf_a !== 1'b0) begin errors++; $display("FAIL reset_new_group ov=%b acc=%0d ovf=%b want 1 20 0", out_valid_a, acc_out_a, ovf_a); end
        tick;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_basic_and_saturation;
        test_back_pressure;
        test_bubbles;
        test_flush;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
